sync_fifo_lvl: RTL

//   Parametrised single-clock show-ahead FIFO: next generation of the team's basic FIFO.

---
 rtl/sync_fifo_lvl_if.sv | 43 ++++
 rtl/sync_fifo_lvl.sv | 87 ++++++++
 2 files changed

// File: rtl/sync_fifo_lvl_if.sv
// Bus bundle for sync_fifo_lvl: producer/consumer handshake, thresholds and status.
// The overflow/underflow signals exist only when FIFO_ERR_EN is defined.
interface sync_fifo_lvl_if #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             flush;
    logic             push;
    logic [WIDTH-1:0] wr_data;
    logic             pop;
    logic [WIDTH-1:0] rd_data;
    logic [CW-1:0]    afull_lvl;
    logic [CW-1:0]    aempty_lvl;
    logic [CW-1:0]    level;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
`ifdef FIFO_ERR_EN
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, push, wr_data, pop, afull_lvl, aempty_lvl,
        input  rd_data, level, full, empty, almost_full, almost_empty, overflow, underflow
    );
    modport slave (
        input  flush, push, wr_data, pop, afull_lvl, aempty_lvl,
        output rd_data, level, full, empty, almost_full, almost_empty, overflow, underflow
    );
`else
    modport master (
        output flush, push, wr_data, pop, afull_lvl, aempty_lvl,
        input  rd_data, level, full, empty, almost_full, almost_empty
    );
    modport slave (
        input  flush, push, wr_data, pop, afull_lvl, aempty_lvl,
        output rd_data, level, full, empty, almost_full, almost_empty
    );
`endif
endinterface

// File: rtl/sync_fifo_lvl.sv
// sync_fifo_lvl: single-clock show-ahead FIFO with arbitrary depth, fill level,
// programmable almost-full/almost-empty thresholds and synchronous flush.
// Optional feature macro: FIFO_ERR_EN adds sticky overflow/underflow flags.
module sync_fifo_lvl #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst,
    sync_fifo_lvl_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    level_q;
    logic             pop_acc;
    logic             push_acc;
    logic             is_full;
    logic             is_empty;

    assign is_full  = (level_q == CW'(DEPTH));
    assign is_empty = (level_q == '0);

    // A pop on a full FIFO frees its slot for a same-cycle push; on an empty
    // FIFO the pop is refused while the push still lands (no bypass path).
    assign pop_acc  = bus.pop & ~is_empty;
    assign push_acc = bus.push & (~is_full | pop_acc);

    // Status outputs are purely combinational from the level counter.
    always_comb begin
        bus.level        = level_q;
        bus.full         = is_full;
        bus.empty        = is_empty;
        bus.almost_full  = (level_q >= bus.afull_lvl);
        bus.almost_empty = (level_q <= bus.aempty_lvl);
        bus.rd_data      = is_empty ? '0 : mem[rd_ptr];
    end

    // Storage write; contents are deliberately not cleared by reset or flush.
    always_ff @(posedge clk) begin
        if (!rst && !bus.flush && push_acc)
            mem[wr_ptr] <= bus.wr_data;
    end

    // Pointers wrap at DEPTH-1 by compare so non-power-of-two depths work.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push_acc)
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop_acc)
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({push_acc, pop_acc})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

`ifdef FIFO_ERR_EN
    logic overflow_q;
    logic underflow_q;

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

    // Sticky error flags: survive flush, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (!bus.flush) begin
            if (bus.push && !push_acc)
                overflow_q <= 1'b1;
            if (bus.pop && !pop_acc)
                underflow_q <= 1'b1;
        end
    end
`endif
endmodule
